// File: rtl/icache_dm_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache.
// Lines are 16 bytes, refilled as two 64-bit beats.
package icache_dm_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        REFILL_REQ  = 2'd1,
        REFILL_WAIT = 2'd2,
        RESPOND     = 2'd3
    } state_t;

    localparam int LINE_BYTES   = 16;
    localparam int LINE_BEATS   = 2;
    localparam int BEAT_W       = 64;
    localparam int WORD_W       = 32;
    localparam int OFFSET_BITS  = $clog2(LINE_BYTES);
    localparam int BEAT_BITS    = $clog2(LINE_BEATS);
    localparam int WORD_SEL_BIT = 2;

    // Little-endian beat: the lower-addressed word sits in the low half.
    function automatic logic [WORD_W-1:0] word_select(input logic [BEAT_W-1:0] beat,
                                                      input logic              hi);
        return hi ? beat[BEAT_W-1:WORD_W] : beat[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/icache_dm_array.sv
// Tag, valid and data storage for icache_dm: synchronous write, combinational read.
// Only the valid bits are reset; tags and data are qualified by them.
module icache_dm_array
    import icache_dm_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int TAG_W      = 54
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] i_index,
    input  logic                  i_flush,
    input  logic                  i_wr_en,
    input  logic [BEAT_BITS-1:0]  i_wr_beat,
    input  logic [BEAT_W-1:0]     i_wr_data,
    input  logic                  i_tag_wr,
    input  logic [TAG_W-1:0]      i_tag,
    input  logic                  i_set_valid,
    output logic                  o_rd_valid,
    output logic [TAG_W-1:0]      o_rd_tag,
    output logic [BEAT_W-1:0]     o_rd_beats [LINE_BEATS]
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag [LINES];

    // Flush wins over a simultaneous set so a flushed refill never lands valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
        end else if (i_set_valid) begin
            r_valid[i_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_tag_wr) begin
            r_tag[i_index] <= i_tag;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LINE_BEATS; gi++) begin : g_beat
            logic [BEAT_W-1:0] r_data [LINES];

            always_ff @(posedge clk) begin
                if (i_wr_en && (i_wr_beat == BEAT_BITS'(gi))) begin
                    r_data[i_index] <= i_wr_data;
                end
            end

            assign o_rd_beats[gi] = r_data[i_index];
        end
    endgenerate

    assign o_rd_valid = r_valid[i_index];
    assign o_rd_tag   = r_tag[i_index];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with two-beat line refill.
// Optional ICACHE_STATS_EN adds saturating hit/miss counters.
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_W     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              wen_i,
    input  logic              flush_i,
    output logic              data_valid_o,
    output logic [31:0]       data_o,
    output logic              mem_req_valid_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ready_i,
    input  logic              mem_rvalid_i,
    input  logic [63:0]       mem_rdata_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int TAG_W = ADDR_W - OFFSET_BITS - INDEX_BITS;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_W-1:0]     r_addr;
    logic [BEAT_BITS-1:0]  r_beat;
    logic                  r_flush_seen;
    logic                  r_data_valid;
    logic [WORD_W-1:0]     r_data;

    logic [ADDR_W-1:0]     w_lookup_addr;
    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_rd_valid;
    logic [TAG_W-1:0]      w_rd_tag;
    logic [BEAT_W-1:0]     w_rd_beats [LINE_BEATS];
    logic                  w_hit;
    logic                  w_miss;
    logic                  w_beat_done;
    logic                  w_last_beat;
    logic [BEAT_BITS-1:0]  w_req_beat;
    logic [BEAT_W-1:0]     w_line_beat;
    logic [WORD_W-1:0]     w_word;
    logic                  w_unused;

    // In IDLE the live address probes the array; otherwise the captured miss address.
    assign w_lookup_addr = (r_state == IDLE) ? addr_i : r_addr;
    assign w_index       = w_lookup_addr[OFFSET_BITS +: INDEX_BITS];
    assign w_tag         = w_lookup_addr[ADDR_W-1 -: TAG_W];

    assign w_hit       = (r_state == IDLE) && req_valid_i && !flush_i
                         && w_rd_valid && (w_rd_tag == w_tag);
    assign w_miss      = (r_state == IDLE) && req_valid_i && !w_hit;
    assign w_beat_done = (r_state == REFILL_WAIT) && mem_rvalid_i;
    assign w_last_beat = w_beat_done && (r_beat == BEAT_BITS'(LINE_BEATS - 1));

    // On the final beat the requested word may still be on the memory bus.
    assign w_req_beat  = w_lookup_addr[OFFSET_BITS-1 -: BEAT_BITS];
    assign w_line_beat = ((r_state == REFILL_WAIT) && (w_req_beat == r_beat))
                         ? mem_rdata_i : w_rd_beats[w_req_beat];
    assign w_word      = word_select(w_line_beat, w_lookup_addr[WORD_SEL_BIT]);

    assign w_unused = ^{wen_i, w_lookup_addr[WORD_SEL_BIT-1:0]};

    icache_dm_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk         (clk),
        .rst         (rst),
        .i_index     (w_index),
        .i_flush     (flush_i),
        .i_wr_en     (w_beat_done),
        .i_wr_beat   (r_beat),
        .i_wr_data   (mem_rdata_i),
        .i_tag_wr    (w_last_beat),
        .i_tag       (w_tag),
        .i_set_valid (w_last_beat && !r_flush_seen && !flush_i),
        .o_rd_valid  (w_rd_valid),
        .o_rd_tag    (w_rd_tag),
        .o_rd_beats  (w_rd_beats)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:        if (w_miss) w_state_next = REFILL_REQ;
            REFILL_REQ:  if (mem_ready_i) w_state_next = REFILL_WAIT;
            REFILL_WAIT: if (mem_rvalid_i) w_state_next = w_last_beat ? RESPOND : REFILL_REQ;
            RESPOND:     w_state_next = IDLE;
            default:     w_state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req_valid_o = 1'b0;
        mem_addr_o      = '0;
        if (r_state == REFILL_REQ) begin
            mem_req_valid_o = 1'b1;
            mem_addr_o      = {r_addr[ADDR_W-1:OFFSET_BITS], r_beat,
                               {(OFFSET_BITS - BEAT_BITS){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr       <= '0;
            r_beat       <= '0;
            r_flush_seen <= 1'b0;
            r_data_valid <= 1'b0;
            r_data       <= '0;
        end else begin
            r_data_valid <= 1'b0;
            if (w_hit || w_last_beat) begin
                r_data_valid <= 1'b1;
                r_data       <= w_word;
            end
            if (w_miss) begin
                r_addr       <= addr_i;
                r_beat       <= '0;
                r_flush_seen <= 1'b0;
            end else if (w_beat_done && !w_last_beat) begin
                r_beat <= r_beat + 1'b1;
            end
            if (flush_i && ((r_state == REFILL_REQ) || (r_state == REFILL_WAIT))) begin
                r_flush_seen <= 1'b1;
            end
        end
    end

    assign data_valid_o = r_data_valid;
    assign data_o       = r_data;

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_miss && (r_miss_cnt != 32'hFFFF_FFFF)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm with a randomised-latency refill memory model.
// Build with ICACHE_STATS_EN defined to also check the hit/miss counters.
module tb_icache_dm;

    localparam int INDEX_BITS = 6;
    localparam int ADDR_W     = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid_i = 1'b0;
    logic [ADDR_W-1:0] addr_i = '0;
    logic              wen_i = 1'b0;
    logic              flush_i = 1'b0;
    logic              data_valid_o;
    logic [31:0]       data_o;
    logic              mem_req_valid_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ready_i = 1'b0;
    logic              mem_rvalid_i = 1'b0;
    logic [63:0]       mem_rdata_i = '0;
`ifdef ICACHE_STATS_EN
    logic [31:0]       hit_cnt_o;
    logic [31:0]       miss_cnt_o;
`endif

    icache_dm #(
        .INDEX_BITS (INDEX_BITS),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid_i),
        .addr_i          (addr_i),
        .wen_i           (wen_i),
        .flush_i         (flush_i),
        .data_valid_o    (data_valid_o),
        .data_o          (data_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_addr_o      (mem_addr_o),
        .mem_ready_i     (mem_ready_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt_o       (hit_cnt_o),
        .miss_cnt_o      (miss_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [63:0] exp_mem_q[$];
    int          cyc = 0;
    int          n_resp = 0;
    int          mem_beats = 0;
    int          mem_req_cycles = 0;
    bit          mem_en = 1'b1;
    bit          hold_resp = 1'b0;
    bit          resp_pending = 1'b0;
    int          resp_delay = 0;
    int          ready_delay = 0;
    logic [63:0] resp_addr = '0;

    function automatic logic [63:0] beat_data(input logic [63:0] a);
        return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
    endfunction

    function automatic logic [31:0] exp_word(input logic [63:0] a);
        logic [63:0] b;
        b = beat_data({a[63:3], 3'b000});
        return a[2] ? b[63:32] : b[31:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        cyc++;
        if (mem_req_valid_o) mem_req_cycles++;
        if (data_valid_o === 1'b1) begin
            n_resp++;
            $display("[TB] cyc %0d response data=0x%08h", cyc, data_o);
            if (exp_q.size() == 0) check("unexpected_dv", {63'b0, data_valid_o}, 64'd0);
            else                   check("rdata", {32'b0, data_o}, {32'b0, exp_q.pop_front()});
        end
    endtask

    task automatic mem_step();
        if (mem_en) begin
            mem_ready_i  = 1'b0;
            mem_rvalid_i = 1'b0;
            if (resp_pending) begin
                if (!hold_resp) begin
                    if (resp_delay == 0) begin
                        mem_rvalid_i = 1'b1;
                        mem_rdata_i  = beat_data(resp_addr);
                        resp_pending = 1'b0;
                    end else begin
                        resp_delay--;
                    end
                end
            end else if (mem_req_valid_o) begin
                if (ready_delay == 0) begin
                    mem_ready_i = 1'b1;
                    mem_beats++;
                    $display("[TB] cyc %0d beat request addr=0x%0h", cyc, mem_addr_o);
                    if (exp_mem_q.size() == 0) check("unexpected_mem_req", {63'b0, mem_req_valid_o}, 64'd0);
                    else                       check("mem_addr", mem_addr_o, exp_mem_q.pop_front());
                    resp_pending = 1'b1;
                    resp_addr    = mem_addr_o;
                    resp_delay   = $urandom_range(0, 2);
                    ready_delay  = $urandom_range(0, 2);
                end else begin
                    ready_delay--;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        mem_step();
    endtask

    // One fetch held until its response; optional flush at issue or inside REFILL_WAIT.
    task automatic fetch(input logic [63:0] a, input bit expect_miss,
                         input bit flush_wait, input bit flush_issue);
        int  beats0;
        int  resp0;
        int  k;
        bit  armed;
        bit  used;
        beats0 = mem_beats;
        resp0  = n_resp;
        armed  = 1'b0;
        used   = 1'b0;
        k      = 0;
        exp_q.push_back(exp_word(a));
        if (expect_miss) begin
            exp_mem_q.push_back({a[63:4], 4'h0});
            exp_mem_q.push_back({a[63:4], 4'h8});
        end
        req_valid_i = 1'b1;
        addr_i      = a;
        flush_i     = flush_issue;
        while (k < 100 && n_resp == resp0) begin
            tick();
            k++;
            flush_i = 1'b0;
            if (armed) begin
                flush_i = 1'b1;
                armed   = 1'b0;
            end
            if (flush_wait && !used && mem_ready_i) begin
                armed = 1'b1;
                used  = 1'b1;
            end
        end
        req_valid_i = 1'b0;
        flush_i     = 1'b0;
        check("resp_seen", 64'(n_resp - resp0), 64'd1);
        check(expect_miss ? "miss_beats" : "hit_beats", 64'(mem_beats - beats0),
              expect_miss ? 64'd2 : 64'd0);
        if (!expect_miss) check("hit_latency", 64'(k), 64'd1);
        if (flush_wait) check("flush_applied", {63'b0, used}, 64'd1);
        tick();
    endtask

    initial begin
        int  resp0;
        int  rq0;
        int  beats0;
        int  k;
        bit  got;

        // Reset state
        repeat (3) tick();
        check("rst_dv",     {63'b0, data_valid_o},    64'd0);
        check("rst_data",   {32'b0, data_o},          64'd0);
        check("rst_memreq", {63'b0, mem_req_valid_o}, 64'd0);
        check("rst_memadr", mem_addr_o,               64'd0);
        rst = 1'b1;
        repeat (2) tick();

        // Cold miss
        fetch(64'h8000_0000, 1'b1, 1'b0, 1'b0);

        // Back-to-back hits on the refilled line
        resp0  = n_resp;
        rq0    = mem_req_cycles;
        beats0 = mem_beats;
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(exp_word(64'h8000_0000 + 64'(4 * i)));
            req_valid_i = 1'b1;
            addr_i      = 64'h8000_0000 + 64'(4 * i);
            tick();
            check("b2b_dv", {63'b0, data_valid_o}, 64'd1);
        end
        req_valid_i = 1'b0;
        tick();
        check("b2b_idle_dv", {63'b0, data_valid_o}, 64'd0);
        check("b2b_count",   64'(n_resp - resp0), 64'd3);
        check("b2b_no_mem",  64'(mem_req_cycles - rq0), 64'd0);
        check("b2b_beats",   64'(mem_beats - beats0), 64'd0);
`ifdef ICACHE_STATS_EN
        check("stats_hit",  {32'b0, hit_cnt_o},  64'd3);
        check("stats_miss", {32'b0, miss_cnt_o}, 64'd1);
`endif

        // Conflict eviction at the same index
        fetch(64'h8000_0400, 1'b1, 1'b0, 1'b0);
        fetch(64'h8000_0000, 1'b1, 1'b0, 1'b0);
        fetch(64'h8000_000C, 1'b0, 1'b0, 1'b0);

        // Flush during refill: response delivered, line left invalid
        fetch(64'h8000_0010, 1'b1, 1'b1, 1'b0);
        fetch(64'h8000_0010, 1'b1, 1'b0, 1'b0);
        fetch(64'h8000_0014, 1'b0, 1'b0, 1'b0);

        // Flush on the request cycle turns a would-be hit into a miss
        fetch(64'h8000_0018, 1'b1, 1'b0, 1'b1);
        fetch(64'h8000_001C, 1'b0, 1'b0, 1'b0);

        // Reset mid-refill, then a stray beat after release
        exp_mem_q.push_back(64'h8000_0020);
        hold_resp   = 1'b1;
        req_valid_i = 1'b1;
        addr_i      = 64'h8000_0020;
        got = 1'b0;
        k   = 0;
        while (k < 50 && !got) begin
            tick();
            k++;
            got = mem_ready_i;
        end
        check("rst_refill_started", {63'b0, got}, 64'd1);
        tick();
        rst = 1'b0;
        #1;
        check("midrst_dv",     {63'b0, data_valid_o},    64'd0);
        check("midrst_data",   {32'b0, data_o},          64'd0);
        check("midrst_memreq", {63'b0, mem_req_valid_o}, 64'd0);
        check("midrst_memadr", mem_addr_o,               64'd0);
`ifdef ICACHE_STATS_EN
        check("midrst_hit",  {32'b0, hit_cnt_o},  64'd0);
        check("midrst_miss", {32'b0, miss_cnt_o}, 64'd0);
`endif
        req_valid_i  = 1'b0;
        resp_pending = 1'b0;
        hold_resp    = 1'b0;
        exp_q.delete();
        exp_mem_q.delete();
        repeat (2) tick();
        rst = 1'b1;
        tick();
        mem_en       = 1'b0;
        mem_ready_i  = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'hDEAD_BEEF_0BAD_F00D;
        resp0 = n_resp;
        tick();
        mem_rvalid_i = 1'b0;
        repeat (2) tick();
        mem_en = 1'b1;
        check("stray_no_dv",   64'(n_resp - resp0),      64'd0);
        check("stray_memreq",  {63'b0, mem_req_valid_o}, 64'd0);
        check("stray_data",    {32'b0, data_o},          64'd0);
        fetch(64'h8000_0000, 1'b1, 1'b0, 1'b0);
        fetch(64'h8000_0020, 1'b1, 1'b0, 1'b0);
`ifdef ICACHE_STATS_EN
        check("post_rst_miss", {32'b0, miss_cnt_o}, 64'd2);
        check("post_rst_hit",  {32'b0, hit_cnt_o},  64'd0);
`endif
        check("scoreboard_empty", 64'(exp_q.size() + exp_mem_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
